// File: rtl/piggy_bank_counter.sv
// Deposit accounting stage: edge-detects debounced coin/break levels, keeps a
// saturating balance, flags goal/full, and pays out on break with a coin lockout.
module piggy_bank_counter #(
  parameter int WIDTH           = 8,
  parameter int COIN_VALUE      = 1,
  parameter int GOAL            = 100,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_in,
  input  logic             break_in,
  output logic [WIDTH-1:0] balance,
  output logic             deposit_pulse,
  output logic             overflow_pulse,
  output logic             goal_met,
  output logic             full,
  output logic             payout_valid,
  output logic [WIDTH-1:0] payout,
  output logic             locked
);

  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [WIDTH:0]   MAX_EXT   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] COIN_W    = WIDTH'(COIN_VALUE);
  localparam logic [WIDTH-1:0] GOAL_W    = WIDTH'(GOAL);
  localparam logic [CW-1:0]    CD_RELOAD = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic {SAVING, COOLDOWN} state_t;

  state_t        state;
  logic [CW-1:0] cd_count;
  logic          coin_prev;
  logic          break_prev;
  logic          coin_evt;
  logic          break_evt;
  logic [WIDTH:0] sum;

  assign coin_evt  = coin_in & ~coin_prev;
  assign break_evt = break_in & ~break_prev;
  // One extra bit so a sum past the top of the range is detectable.
  assign sum       = {1'b0, balance} + {1'b0, COIN_W};

  assign goal_met = (balance >= GOAL_W);
  assign full     = (balance == {WIDTH{1'b1}});
  assign locked   = (state == COOLDOWN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SAVING;
      cd_count       <= '0;
      coin_prev      <= 1'b1;
      break_prev     <= 1'b1;
      balance        <= '0;
      payout         <= '0;
      deposit_pulse  <= 1'b0;
      overflow_pulse <= 1'b0;
      payout_valid   <= 1'b0;
    end else begin
      coin_prev      <= coin_in;
      break_prev     <= break_in;
      deposit_pulse  <= 1'b0;
      overflow_pulse <= 1'b0;
      payout_valid   <= 1'b0;
      case (state)
        SAVING: begin
          // A break wins over a coin arriving on the same edge.
          if (break_evt) begin
            payout       <= balance;
            payout_valid <= 1'b1;
            balance      <= '0;
            cd_count     <= CD_RELOAD;
            state        <= COOLDOWN;
          end else if (coin_evt) begin
            deposit_pulse <= 1'b1;
            if (sum > MAX_EXT) begin
              balance        <= {WIDTH{1'b1}};
              overflow_pulse <= 1'b1;
            end else begin
              balance <= sum[WIDTH-1:0];
            end
          end
        end
        COOLDOWN: begin
          if (cd_count == '0) state <= SAVING;
          else                cd_count <= cd_count - CW'(1);
        end
        default: state <= SAVING;
      endcase
    end
  end

endmodule

// File: doc/piggy_bank_counter.md
# piggy_bank_counter

Deposit accounting stage that sits directly downstream of the coin-button debouncer. It turns the debounced coin and break levels into single-event pulses and keeps a saturating balance. It flags when a savings goal is reached, and on a "break" event presents the full balance as a one-cycle payout, clears the balance, and ignores coins for a cooldown window. Its outputs drive the top-level `uo_out` display bits in place of the raw debouncer level.

## Interface
Parameters:
- `WIDTH`, 8: balance/payout width in bits (≥ 2).
- `COIN_VALUE`, 1: amount added per accepted coin (1 .. 2^WIDTH-1).
- `GOAL`, 100: goal threshold (1 .. 2^WIDTH-1).
- `COOLDOWN_CYCLES`, 16: coin-lockout length after a break (≥ 1).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `coin_in`  in  1  debounced coin level, already synchronous to `clk`.
- `break_in`  in  1  debounced break level, already synchronous to `clk`.
- `balance`  out  WIDTH  current saved amount.
- `deposit_pulse`  out  1  one-cycle strobe per accepted coin.
- `overflow_pulse`  out  1  one-cycle strobe when an accepted coin saturated the balance.
- `goal_met`  out  1  high while `balance >= GOAL`.
- `full`  out  1  high while `balance == 2^WIDTH-1`.
- `payout_valid`  out  1  one-cycle strobe on break.
- `payout`  out  WIDTH  balance captured at break; holds its value until the next break.
- `locked`  out  1  high while in COOLDOWN.

## Operation
- **Edge detection.**
  - Registers `coin_prev` and `break_prev` both reset to 1. A level held high through reset release therefore produces no event.
  - Coin event: `coin_in & ~coin_prev`. Break event: `break_in & ~break_prev`.
  - The prev registers update every cycle in every state.
- **State machine** (2 states: SAVING, COOLDOWN; reset → SAVING).
  - SAVING, break event:
    - `payout <= balance` (the pre-coin value).
    - `payout_valid` pulses.
    - `balance <= 0`.
    - cooldown counter `<= COOLDOWN_CYCLES-1`.
    - next state COOLDOWN.
    - Any coin event in the same cycle is discarded: no `deposit_pulse`.
  - SAVING, coin event only:
    - `balance <= min(balance + COIN_VALUE, 2^WIDTH-1)`, computed at WIDTH+1 bits.
    - `deposit_pulse` pulses.
    - `overflow_pulse` pulses if the unclamped sum exceeded 2^WIDTH-1, including a coin at `full`. At `full`, the balance is unchanged but the coin is still acknowledged.
  - COOLDOWN:
    - Coin events and break events are ignored.
    - The counter decrements each cycle; at 0, next state is SAVING.
    - COOLDOWN lasts exactly COOLDOWN_CYCLES cycles.
    - A coin held high across the COOLDOWN → SAVING transition does not count, because `coin_prev` is already 1.
- **Flags.** `goal_met`, `full` and `locked` are pure decodes of registered `balance`/state, with no extra latency.
- **Reset** (asserted at any time, including mid-cooldown or mid-pulse):
  - `balance`, `payout`, all pulses, `locked` go to 0 immediately.
  - `goal_met` and `full` go to 0.
  - State goes to SAVING.

## Timing
- Coin or break sampled high (with prev = 0) at rising edge t:
  - `balance`, `deposit_pulse`, `payout_valid`, `payout` update at edge t.
  - They are visible during cycle t..t+1.
  - Latency: 1 clock from the first high sample.
- All pulses are exactly 1 cycle wide and are registered outputs.
- Back-to-back coin events need at least one low cycle between them, so the maximum rate is one accepted coin per 2 cycles.
- Break at edge t: `locked` is high from t through t+COOLDOWN_CYCLES. The first coin event that can be accepted is sampled at edge t+COOLDOWN_CYCLES+1.

## Test plan
- **Reset/hold:** hold `coin_in=1` through `rst` deassertion → `balance=0`, no `deposit_pulse`. Then drop and raise `coin_in` → `balance=1`, one `deposit_pulse`.
- **Goal:** `GOAL=3`, three coin pulses 4 cycles apart → `balance` steps 1,2,3. `goal_met` rises on the same cycle `balance=3`.
- **Saturation:** `WIDTH=4`, `COIN_VALUE=5`, four coins → `balance` 5,10,15,15. `full` is set at 15. `overflow_pulse` fires on the 4th coin only; `deposit_pulse` fires on all 4.
- **Break:** `balance=7`, break pulse → `payout=7`, `payout_valid` high exactly 1 cycle, `balance=0`, `goal_met` low. `locked` is high for exactly `COOLDOWN_CYCLES`=16 cycles. Coins during those cycles are ignored. A coin 1 cycle after `locked` falls counts.
- **Simultaneous:** coin and break rise on the same edge with `balance=4` → `payout=4`, `balance=0`, no `deposit_pulse`.
- **Reset mid-cooldown:** assert `rst` 5 cycles into COOLDOWN → `locked=0` and `payout=0` immediately. After release, a fresh coin is accepted normally.
